// File: rtl/llc_bus_msg_queue.sv
// -----------------------------------------------------------------------------
// llc_bus_msg_queue
//
// Output stage of the LLC controller. Every cycle the controller may present
// one result (bus operation, snoop result, L1 message, address). The result
// is split into two independent FIFOs:
//   - bus channel : {bus op, line-aligned address, snoop result}
//   - msg channel : {L1 message code, full address}
// Each channel is drained through its own valid/ready handshake. The LLC
// cannot be stalled, so a push into a full channel (with no pop in the same
// cycle) is discarded and counted in a saturating drop counter.
//
// Trace op 8 (clear) empties both channels and zeroes the drop counters.
// Trace op 9 (print) pushes nothing.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_op/in_addr          LLC result strobe, trace op, address
//   in_busop/in_snoop/in_msg        bus op, snoop result, L1 message
//   bus_valid/bus_ready             bus channel handshake
//   bus_op/bus_addr/bus_snoop       registered head of the bus channel
//   msg_valid/msg_ready             msg channel handshake
//   msg_code/msg_addr               registered head of the msg channel
//   bus_count/msg_count             channel occupancy
//   bus_drops/msg_drops             saturating overflow counters
// -----------------------------------------------------------------------------

// Single-channel FIFO with registered head, count-based occupancy and a
// saturating overflow counter.
module llc_bus_msg_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         ready,
   output logic                         valid,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_W-1:0]             drops
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CNT_W-1:0] drops_r;
   logic             valid_r;
   logic [WIDTH-1:0] head_r;

   logic             pop_s;
   logic             full_s;
   logic             accept_s;
   logic             drop_s;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic [PTR_W-1:0] wr_ptr_nxt_s;
   logic [CW-1:0]    count_after_pop_s;
   logic [CW-1:0]    count_nxt_s;
   logic [CNT_W-1:0] drops_nxt_s;
   logic [WIDTH-1:0] head_nxt_s;

   // Next-state computation for pointers, occupancy, drops and the head register.
   always_comb begin
      pop_s             = valid_r && ready && !clear;
      full_s            = (count_r == FULL_CNT);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      accept_s          = push && !clear && (!full_s || pop_s);
      drop_s            = push && !clear && full_s && !pop_s;
      rd_ptr_nxt_s      = rd_ptr_r + PTR_W'(pop_s);
      wr_ptr_nxt_s      = wr_ptr_r + PTR_W'(accept_s);
      count_after_pop_s = count_r - CW'(pop_s);
      count_nxt_s       = count_after_pop_s + CW'(accept_s);

      if (drop_s && (drops_r != {CNT_W{1'b1}})) begin
         drops_nxt_s = drops_r + CNT_W'(1'b1);
      end else begin
         drops_nxt_s = drops_r;
      end

      // The head register must show the entry that will be at the head after
      // this edge. When the FIFO is (or becomes) empty before the push, that
      // entry is the one being written now, which is not yet in mem_r.
      if (count_nxt_s == {CW{1'b0}}) begin
         head_nxt_s = {WIDTH{1'b0}};
      end else if (count_after_pop_s == {CW{1'b0}}) begin
         head_nxt_s = push_data;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Control state: reset and clear both return the channel to empty.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CW{1'b0}};
         drops_r  <= {CNT_W{1'b0}};
         valid_r  <= 1'b0;
         head_r   <= {WIDTH{1'b0}};
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_nxt_s;
         count_r  <= count_nxt_s;
         drops_r  <= drops_nxt_s;
         valid_r  <= (count_nxt_s != {CW{1'b0}});
         head_r   <= head_nxt_s;
      end
   end

   // Entry storage; contents are don't-care while not covered by count_r.
   always_ff @(posedge clk) begin
      if (accept_s && !reset) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign valid = valid_r;
   assign head  = head_r;
   assign count = count_r;
   assign drops = drops_r;
endmodule

// Top level: decode the LLC result into the two channel pushes.
module llc_bus_msg_queue #(
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 32,
   parameter int LINE_OFFSET = 6,
   parameter int CNT_W       = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [3:0]                  in_op,
   input  logic [ADDR_W-1:0]           in_addr,
   input  logic [2:0]                  in_busop,
   input  logic [1:0]                  in_snoop,
   input  logic [2:0]                  in_msg,
   output logic                        bus_valid,
   input  logic                        bus_ready,
   output logic [2:0]                  bus_op,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic [1:0]                  bus_snoop,
   output logic                        msg_valid,
   input  logic                        msg_ready,
   output logic [2:0]                  msg_code,
   output logic [ADDR_W-1:0]           msg_addr,
   output logic [$clog2(DEPTH+1)-1:0]  bus_count,
   output logic [$clog2(DEPTH+1)-1:0]  msg_count,
   output logic [CNT_W-1:0]            bus_drops,
   output logic [CNT_W-1:0]            msg_drops
);
   localparam int BUS_W = 3 + ADDR_W + 2;
   localparam int MSG_W = 3 + ADDR_W;

   logic              is_cmd_s;
   logic              clear_s;
   logic              bus_push_s;
   logic              msg_push_s;
   logic [ADDR_W-1:0] line_addr_s;
   logic [BUS_W-1:0]  bus_entry_s;
   logic [MSG_W-1:0]  msg_entry_s;
   logic [BUS_W-1:0]  bus_head_s;
   logic [MSG_W-1:0]  msg_head_s;

   // Decode trace commands and build the entries for each channel.
   always_comb begin
      // Ops 8 (clear) and 9 (print) never carry a bus op or message.
      is_cmd_s    = (in_op == 4'd8) || (in_op == 4'd9);
      clear_s     = in_valid && (in_op == 4'd8);
      bus_push_s  = in_valid && !is_cmd_s && (in_busop != 3'd0);
      msg_push_s  = in_valid && !is_cmd_s && (in_msg != 3'd0);
      line_addr_s = {in_addr[ADDR_W-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
      bus_entry_s = {in_busop, line_addr_s, in_snoop};
      msg_entry_s = {in_msg, in_addr};
   end

   llc_bus_msg_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BUS_W),
      .CNT_W (CNT_W)
   ) u_bus_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_s),
      .push      (bus_push_s),
      .push_data (bus_entry_s),
      .ready     (bus_ready),
      .valid     (bus_valid),
      .head      (bus_head_s),
      .count     (bus_count),
      .drops     (bus_drops)
   );

   llc_bus_msg_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (MSG_W),
      .CNT_W (CNT_W)
   ) u_msg_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_s),
      .push      (msg_push_s),
      .push_data (msg_entry_s),
      .ready     (msg_ready),
      .valid     (msg_valid),
      .head      (msg_head_s),
      .count     (msg_count),
      .drops     (msg_drops)
   );

   assign {bus_op, bus_addr, bus_snoop} = bus_head_s;
   assign {msg_code, msg_addr}          = msg_head_s;
endmodule

// File: tb/tb_llc_bus_msg_queue.sv
// -----------------------------------------------------------------------------
// tb_llc_bus_msg_queue
//
// Directed scenarios for reset, single entry, overflow, full push+pop and the
// clear/print commands, followed by random traffic checked against a
// queue-based scoreboard.
// -----------------------------------------------------------------------------
module tb_llc_bus_msg_queue;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [3:0]  in_op;
   logic [31:0] in_addr;
   logic [2:0]  in_busop;
   logic [1:0]  in_snoop;
   logic [2:0]  in_msg;
   logic        bus_valid;
   logic        bus_ready;
   logic [2:0]  bus_op;
   logic [31:0] bus_addr;
   logic [1:0]  bus_snoop;
   logic        msg_valid;
   logic        msg_ready;
   logic [2:0]  msg_code;
   logic [31:0] msg_addr;
   logic [CW-1:0] bus_count;
   logic [CW-1:0] msg_count;
   logic [15:0] bus_drops;
   logic [15:0] msg_drops;

   int total = 0;
   int bad   = 0;

   logic [36:0] bus_q [$];
   logic [34:0] msg_q [$];
   int bus_drop_m;
   int msg_drop_m;
   int bus_accepts;
   int msg_accepts;

   llc_bus_msg_queue #(
      .DEPTH (DEPTH), .ADDR_W (32), .LINE_OFFSET (6), .CNT_W (16)
   ) dut (
      .clk (clk), .reset (reset),
      .in_valid (in_valid), .in_op (in_op), .in_addr (in_addr),
      .in_busop (in_busop), .in_snoop (in_snoop), .in_msg (in_msg),
      .bus_valid (bus_valid), .bus_ready (bus_ready), .bus_op (bus_op),
      .bus_addr (bus_addr), .bus_snoop (bus_snoop),
      .msg_valid (msg_valid), .msg_ready (msg_ready), .msg_code (msg_code),
      .msg_addr (msg_addr),
      .bus_count (bus_count), .msg_count (msg_count),
      .bus_drops (bus_drops), .msg_drops (msg_drops)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [2:0] bo, input logic [1:0] sn, input logic [2:0] m);
      in_valid = v;
      in_op    = op;
      in_addr  = a;
      in_busop = bo;
      in_snoop = sn;
      in_msg   = m;
   endtask

   task automatic set_idle();
      set_in(1'b0, 4'd0, 32'd0, 3'd0, 2'd0, 3'd0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_ready = 1'b0;
      msg_ready = 1'b0;
      set_idle();
      repeat (3) tick();
      reset = 1'b0;
      tick();
      total++;
      if ({bus_valid, msg_valid, bus_op, bus_addr, bus_snoop, msg_code, msg_addr,
           bus_count, msg_count, bus_drops, msg_drops} !== 113'd0) begin
         bad++;
         $display("FAIL reset_outputs: got bv=%b mv=%b bop=%h ba=%h bs=%h mc=%h ma=%h bc=%0d mc=%0d bd=%0d md=%0d want all 0",
                  bus_valid, msg_valid, bus_op, bus_addr, bus_snoop, msg_code, msg_addr,
                  bus_count, msg_count, bus_drops, msg_drops);
      end
      for (int i = 0; i < 10; i++) begin
         bus_ready = 1'($urandom_range(0, 1));
         msg_ready = 1'($urandom_range(0, 1));
         tick();
         total++;
         if ({bus_valid, msg_valid} !== 2'b00) begin
            bad++;
            $display("FAIL idle_valid[%0d]: got bv=%b mv=%b want 0 0", i, bus_valid, msg_valid);
         end
      end
      bus_ready = 1'b0;
      msg_ready = 1'b0;
   endtask

   task automatic test_single();
      set_in(1'b1, 4'd0, 32'h1234_5678, 3'd1, 2'd1, 3'd2);
      tick();
      set_idle();
      for (int i = 0; i < 6; i++) begin
         total++;
         if ({bus_valid, bus_op, bus_addr, bus_snoop} !== {1'b1, 3'd1, 32'h1234_5640, 2'd1}) begin
            bad++;
            $display("FAIL single_bus[%0d]: got v=%b op=%0d addr=%h snoop=%0d want 1 1 12345640 1",
                     i, bus_valid, bus_op, bus_addr, bus_snoop);
         end
         total++;
         if ({msg_valid, msg_code, msg_addr} !== {1'b1, 3'd2, 32'h1234_5678}) begin
            bad++;
            $display("FAIL single_msg[%0d]: got v=%b code=%0d addr=%h want 1 2 12345678",
                     i, msg_valid, msg_code, msg_addr);
         end
         total++;
         if ({bus_count, msg_count} !== {4'd1, 4'd1}) begin
            bad++;
            $display("FAIL single_count[%0d]: got %0d %0d want 1 1", i, bus_count, msg_count);
         end
         if (i < 5) tick();
      end
      bus_ready = 1'b1;
      msg_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      msg_ready = 1'b0;
      total++;
      if ({bus_valid, msg_valid, bus_count, msg_count} !== 10'd0) begin
         bad++;
         $display("FAIL single_drain: got bv=%b mv=%b bc=%0d mc=%0d want 0 0 0 0",
                  bus_valid, msg_valid, bus_count, msg_count);
      end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 10; k++) begin
         set_in(1'b1, 4'd1, 32'(k * 32'h40), 3'd2, 2'd0, 3'd0);
         tick();
      end
      set_idle();
      total++;
      if ({bus_count, bus_drops, msg_count, msg_valid} !== {4'd8, 16'd2, 4'd0, 1'b0}) begin
         bad++;
         $display("FAIL overflow_state: got bc=%0d bd=%0d mc=%0d mv=%b want 8 2 0 0",
                  bus_count, bus_drops, msg_count, msg_valid);
      end
      bus_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         total++;
         if ({bus_valid, bus_op, bus_addr} !== {1'b1, 3'd2, 32'(k * 32'h40)}) begin
            bad++;
            $display("FAIL overflow_drain[%0d]: got v=%b op=%0d addr=%h want 1 2 %h",
                     k, bus_valid, bus_op, bus_addr, 32'(k * 32'h40));
         end
         tick();
      end
      bus_ready = 1'b0;
      total++;
      if ({bus_valid, bus_count, bus_drops} !== {1'b0, 4'd0, 16'd2}) begin
         bad++;
         $display("FAIL overflow_empty: got v=%b bc=%0d bd=%0d want 0 0 2", bus_valid, bus_count, bus_drops);
      end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp;
      for (int k = 0; k < 8; k++) begin
         set_in(1'b1, 4'd1, 32'h1000 + 32'(k * 32'h40), 3'd4, 2'd2, 3'd0);
         tick();
      end
      set_in(1'b1, 4'd1, 32'h2000, 3'd4, 2'd2, 3'd0);
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      set_idle();
      total++;
      if ({bus_count, bus_drops} !== {4'd8, 16'd2}) begin
         bad++;
         $display("FAIL full_pushpop_state: got bc=%0d bd=%0d want 8 2", bus_count, bus_drops);
      end
      bus_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp = (k < 7) ? 32'h1040 + 32'(k * 32'h40) : 32'h2000;
         total++;
         if ({bus_valid, bus_op, bus_addr, bus_snoop} !== {1'b1, 3'd4, exp, 2'd2}) begin
            bad++;
            $display("FAIL full_pushpop_drain[%0d]: got v=%b op=%0d addr=%h sn=%0d want 1 4 %h 2",
                     k, bus_valid, bus_op, bus_addr, bus_snoop, exp);
         end
         tick();
      end
      bus_ready = 1'b0;
   endtask

   task automatic test_clear();
      for (int k = 0; k < 9; k++) begin
         set_in(1'b1, 4'd2, 32'h3000 + 32'(k * 32'h40), 3'd1, 2'd0, 3'd1);
         tick();
      end
      set_idle();
      bus_ready = 1'b1;
      repeat (3) tick();
      bus_ready = 1'b0;
      total++;
      if ({bus_count, bus_drops, msg_count, msg_drops} !== {4'd5, 16'd3, 4'd8, 16'd1}) begin
         bad++;
         $display("FAIL clear_setup: got bc=%0d bd=%0d mc=%0d md=%0d want 5 3 8 1",
                  bus_count, bus_drops, msg_count, msg_drops);
      end
      bus_ready = 1'b1;
      msg_ready = 1'b1;
      set_in(1'b1, 4'd8, 32'h5000, 3'd1, 2'd0, 3'd1);
      tick();
      set_idle();
      bus_ready = 1'b0;
      msg_ready = 1'b0;
      total++;
      if ({bus_valid, msg_valid, bus_op, bus_addr, bus_snoop, msg_code, msg_addr,
           bus_count, msg_count, bus_drops, msg_drops} !== 113'd0) begin
         bad++;
         $display("FAIL clear_outputs: got bv=%b mv=%b ba=%h ma=%h bc=%0d mc=%0d bd=%0d md=%0d want all 0",
                  bus_valid, msg_valid, bus_addr, msg_addr, bus_count, msg_count, bus_drops, msg_drops);
      end
      set_in(1'b1, 4'd9, 32'h6000, 3'd1, 2'd1, 3'd1);
      tick();
      set_in(1'b1, 4'd3, 32'h7000, 3'd0, 2'd2, 3'd0);
      tick();
      set_idle();
      tick();
      total++;
      if ({bus_valid, msg_valid, bus_count, msg_count} !== 10'd0) begin
         bad++;
         $display("FAIL nopush_cmds: got bv=%b mv=%b bc=%0d mc=%0d want 0 0 0 0",
                  bus_valid, msg_valid, bus_count, msg_count);
      end
   endtask

   task automatic test_random();
      logic [36:0] bexp;
      logic [34:0] mexp;
      int thr;
      int r;
      bus_q.delete();
      msg_q.delete();
      bus_drop_m  = 0;
      msg_drop_m  = 0;
      bus_accepts = 0;
      msg_accepts = 0;
      for (int i = 0; i < 2000; i++) begin
         total++;
         if ({bus_valid, bus_count, bus_drops} !== {1'(bus_q.size() != 0), CW'(bus_q.size()), 16'(bus_drop_m)}) begin
            bad++;
            $display("FAIL rand_bus_state[%0d]: got v=%b c=%0d d=%0d want %0d %0d %0d",
                     i, bus_valid, bus_count, bus_drops, bus_q.size() != 0, bus_q.size(), bus_drop_m);
         end
         total++;
         if ({msg_valid, msg_count, msg_drops} !== {1'(msg_q.size() != 0), CW'(msg_q.size()), 16'(msg_drop_m)}) begin
            bad++;
            $display("FAIL rand_msg_state[%0d]: got v=%b c=%0d d=%0d want %0d %0d %0d",
                     i, msg_valid, msg_count, msg_drops, msg_q.size() != 0, msg_q.size(), msg_drop_m);
         end
         thr = (i < 1000) ? 30 : 70;
         bus_ready = ($urandom_range(0, 99) < thr);
         msg_ready = ($urandom_range(0, 99) < thr);
         r = int'($urandom_range(0, 199));
         in_valid = ($urandom_range(0, 3) != 0);
         in_op    = (r == 0) ? 4'd8 : (r < 6) ? 4'd9 : 4'($urandom_range(0, 7));
         in_addr  = $urandom;
         in_busop = 3'($urandom_range(0, 4));
         in_snoop = 2'($urandom_range(0, 3));
         in_msg   = 3'($urandom_range(0, 4));
         if (in_valid && in_op == 4'd8) begin
            bus_q.delete();
            msg_q.delete();
            bus_drop_m = 0;
            msg_drop_m = 0;
         end else begin
            if (bus_q.size() != 0 && bus_ready) begin
               bexp = bus_q.pop_front();
               total++;
               if ({bus_op, bus_addr, bus_snoop} !== bexp) begin
                  bad++;
                  $display("FAIL rand_bus_data[%0d]: got %h want %h", i, {bus_op, bus_addr, bus_snoop}, bexp);
               end
            end
            if (msg_q.size() != 0 && msg_ready) begin
               mexp = msg_q.pop_front();
               total++;
               if ({msg_code, msg_addr} !== mexp) begin
                  bad++;
                  $display("FAIL rand_msg_data[%0d]: got %h want %h", i, {msg_code, msg_addr}, mexp);
               end
            end
            if (in_valid && in_op != 4'd9 && in_busop != 3'd0) begin
               if (bus_q.size() < DEPTH) begin
                  bus_q.push_back({in_busop, in_addr & 32'hFFFF_FFC0, in_snoop});
                  bus_accepts++;
               end else if (bus_drop_m < 65535) begin
                  bus_drop_m++;
               end
            end
            if (in_valid && in_op != 4'd9 && in_msg != 3'd0) begin
               if (msg_q.size() < DEPTH) begin
                  msg_q.push_back({in_msg, in_addr});
                  msg_accepts++;
               end else if (msg_drop_m < 65535) begin
                  msg_drop_m++;
               end
            end
         end
         tick();
      end
      set_idle();
      bus_ready = 1'b0;
      msg_ready = 1'b0;
      total++;
      if (bus_accepts < 50 * DEPTH || msg_accepts < 50 * DEPTH) begin
         bad++;
         $display("FAIL rand_wrap_coverage: got bus=%0d msg=%0d accepts want >= %0d",
                  bus_accepts, msg_accepts, 50 * DEPTH);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/llc_bus_msg_queue.md
Name: llc_bus_msg_queue

Overview:
- Downstream stage of the LLC controller. Each cycle it captures the controller's per-operation results (bus operation, snoop result, L1 message, address).
- Splits them into two independent FIFOs: a bus-transaction channel and an L1-message channel. Each is drained by its consumer (bus model, L1 model/logger) through a valid/ready handshake.
- Absorbs bursts, because the LLC cannot be back-pressured. Counts entries dropped on overflow.

Parameters:
- DEPTH, 8, entries per FIFO (power of two, >=2)
- ADDR_W, 32, address width
- LINE_OFFSET, 6, low address bits zeroed on the bus channel (line-aligned address)
- CNT_W, 16, width of the saturating drop counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  LLC result valid this cycle
- in_op  in  4  trace op of this result (0-9)
- in_addr  in  ADDR_W  trace address
- in_busop  in  3  NOBUSOP=0 READ=1 WRITE=2 INVALIDATE=3 RWIM=4
- in_snoop  in  2  NOHIT=0 HIT=1 HITM=2 NORESULT=3
- in_msg  in  3  NOMESSAGE=0 GETLINE=1 SENDLINE=2 INVALIDATELINE=3 EVICTLINE=4
- bus_valid  out  1  bus entry available
- bus_ready  in  1  bus consumer accepts
- bus_op  out  3  queued bus operation
- bus_addr  out  ADDR_W  line-aligned address
- bus_snoop  out  2  snoop result captured with the op
- msg_valid  out  1  L1 message entry available
- msg_ready  in  1  L1 consumer accepts
- msg_code  out  3  queued L1 message
- msg_addr  out  ADDR_W  full address
- bus_count  out  $clog2(DEPTH+1)  bus FIFO occupancy
- msg_count  out  $clog2(DEPTH+1)  msg FIFO occupancy
- bus_drops  out  CNT_W  saturating bus-overflow count
- msg_drops  out  CNT_W  saturating msg-overflow count

Behaviour:
- All state on posedge clk. Reset is synchronous, active-high, and has priority over everything else.
- Reset values:
  - both FIFOs empty
  - bus_valid = msg_valid = 0
  - counts = 0, drops = 0
  - data outputs = 0
- Clear command: in_valid with in_op==8 behaves exactly like reset, one cycle later-visible. It empties both FIFOs and zeroes the drop counters. Nothing is pushed that cycle. Pops presented in that cycle are discarded.
- Print command: in_op==9 pushes nothing.
- Bus push condition: in_valid && in_op not in {8,9} && in_busop != NOBUSOP.
  - Pushed entry: {in_busop, in_addr with bits [LINE_OFFSET-1:0] zeroed, in_snoop}.
- Msg push condition: in_valid && in_op not in {8,9} && in_msg != NOMESSAGE.
  - Pushed entry: {in_msg, in_addr}.
  - One input can push both FIFOs in the same cycle.
- Pop: a FIFO pops when x_valid && x_ready.
  - Outputs are registered and show the head entry.
  - x_valid = (x_count != 0).
  - Outputs must hold stable while x_valid && !x_ready.
- Latency: a push into an empty FIFO in cycle N gives x_valid=1 with that entry in cycle N+1. There is no combinational input-to-output path.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by count, not by pointer compare.
- Simultaneous push and pop:
  - count unchanged
  - head advances
  - new entry written at tail
  - allowed when full: the pop frees the slot, so no drop
  - when empty, the pop is impossible (valid=0), so it is a push only
- Overflow: push when count==DEPTH and no pop that cycle.
  - Entry discarded; FIFO contents unchanged.
  - x_drops increments, saturating at 2^CNT_W-1.
- Bus and msg channels are fully independent: their drops, counts and handshakes do not affect each other.
- x_ready while empty has no effect.

Test Plan:
- Reset then idle -> all outputs 0; bus_valid=msg_valid=0 for 10 cycles with random ready.
- One input: op=0, addr=0x1234_5678, busop=READ, snoop=HIT, msg=SENDLINE, with ready=0 -> next cycle:
  - bus_valid=1, bus_op=1, bus_addr=0x1234_5640, bus_snoop=1
  - msg_valid=1, msg_code=2, msg_addr=0x1234_5678
  - both counts=1
  - entry held stable 5 cycles; one ready pulse empties each FIFO.
- Push 10 bus-only ops (addr 0x40*k, k=0..9) with bus_ready=0 ->
  - bus_count=8, bus_drops=2
  - drain yields addrs 0x000..0x1C0 in order
  - msg_count stays 0
- Full FIFO plus simultaneous push and pop -> count stays 8, drops unchanged, the new entry appears last in the drain order.
- op=8 with 5 entries queued and drops=3 -> next cycle counts=0, drops=0, valids=0. op=9 and NOBUSOP/NOMESSAGE inputs push nothing.
- Random 2000-cycle push/ready traffic vs scoreboard model -> ordering, counts and drop totals match exactly; pointer wrap exercised at least 50 times.
